// File: rtl/arithmetic_logic_unit.sv
// Registered WIDTH-bit ALU with one-hot operation strobes resolved by fixed priority.
// Holds an internal data register (sr.dataReg) that LSR loads from in1.
module arithmetic_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             LSR,
  input  logic             LSH,
  input  logic             RSH,
  input  logic             AND,
  input  logic             OR,
  input  logic             XOR,
  input  logic             INV,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [WIDTH-1:0] sr_q
);

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_LSR,
    OP_LSH,
    OP_RSH,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_INV
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             ov_d;
  logic             upd;

  // Bit WIDTH of the extended sum is the carry; of the extended difference, the borrow.
  assign sum  = {1'b0, in1} + {1'b0, in2};
  assign diff = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    op = OP_NONE;
    if      (ADD) op = OP_ADD;
    else if (SUB) op = OP_SUB;
    else if (LSR) op = OP_LSR;
    else if (LSH) op = OP_LSH;
    else if (RSH) op = OP_RSH;
    else if (AND) op = OP_AND;
    else if (OR)  op = OP_OR;
    else if (XOR) op = OP_XOR;
    else if (INV) op = OP_INV;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    res_d = '0;
    ov_d  = 1'b0;
    upd   = 1'b1;
    case (op)
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        ov_d  = sum[WIDTH];
      end
      OP_SUB: begin
        res_d = diff[WIDTH-1:0];
        ov_d  = diff[WIDTH];
      end
      OP_LSH: begin
        res_d = {in1[WIDTH-2:0], 1'b0};
        ov_d  = in1[WIDTH-1];
      end
      OP_RSH: begin
        res_d = {1'b0, in1[WIDTH-1:1]};
        ov_d  = in1[0];
      end
      OP_AND:  res_d = in1 & in2;
      OP_OR:   res_d = in1 | in2;
      OP_XOR:  res_d = in1 ^ in2;
      OP_INV:  res_d = ~in1;
      default: upd   = 1'b0;  // OP_NONE and OP_LSR leave out/overflow untouched
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (upd) begin
      out      <= res_d;
      overflow <= ov_d;
    end
  end

  if (1'b1) begin : sr
    logic [WIDTH-1:0] dataReg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           dataReg <= '0;
      else if (op == OP_LSR) dataReg <= in1;
    end

    assign sr_q = dataReg;
  end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Bench for arithmetic_logic_unit: directed test-plan steps then random strobes/operands,
// compared each cycle against an arithmetic reference model.
module tb_arithmetic_logic_unit;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         ADD, SUB, LSR, LSH, RSH, AND, OR, XOR, INV;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out;
  logic         overflow;
  logic [W-1:0] sr_q;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_out = 0;
  int m_ov  = 0;
  int m_sr  = 0;

  always #5 clk = ~clk;

  arithmetic_logic_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .ADD      (ADD),
    .SUB      (SUB),
    .LSR      (LSR),
    .LSH      (LSH),
    .RSH      (RSH),
    .AND      (AND),
    .OR       (OR),
    .XOR      (XOR),
    .INV      (INV),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .overflow (overflow),
    .sr_q     (sr_q)
  );

  // Strobe vector bit order: [0]=ADD [1]=SUB [2]=LSR [3]=LSH [4]=RSH [5]=AND [6]=OR [7]=XOR [8]=INV
  localparam logic [8:0] S_ADD = 9'h001, S_SUB = 9'h002, S_LSR = 9'h004, S_LSH = 9'h008,
                         S_RSH = 9'h010, S_AND = 9'h020, S_OR  = 9'h040, S_XOR = 9'h080,
                         S_INV = 9'h100, S_NONE = 9'h000;

  task automatic drive(input logic [8:0] st, input int a, input int b);
    {INV, XOR, OR, AND, RSH, LSH, LSR, SUB, ADD} = st;
    in1 = W'(a);
    in2 = W'(b);
  endtask

  task automatic model_reset();
    m_out = 0;
    m_ov  = 0;
    m_sr  = 0;
  endtask

  task automatic model_apply(input logic [8:0] st, input int a, input int b);
    int sel;
    sel = -1;
    for (int i = 0; i < 9; i++) if (st[i] && sel < 0) sel = i;
    case (sel)
      0: begin m_out = (a + b) % MOD;       m_ov = (a + b >= MOD); end
      1: begin m_out = (a - b + MOD) % MOD; m_ov = (a < b);        end
      2: m_sr = a;
      3: begin m_out = (a * 2) % MOD;       m_ov = (a >= MOD / 2); end
      4: begin m_out = a / 2;               m_ov = a % 2;          end
      5: begin m_out = a & b;               m_ov = 0;              end
      6: begin m_out = a | b;               m_ov = 0;              end
      7: begin m_out = a ^ b;               m_ov = 0;              end
      8: begin m_out = MOD - 1 - a;         m_ov = 0;              end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},      32'(out),      32'(m_out));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    check({tag, ".sr_q"},     32'(sr_q),     32'(m_sr));
  endtask

  task automatic step(input string tag, input logic [8:0] st, input int a, input int b);
    @(negedge clk);
    drive(st, a, b);
    @(posedge clk);
    model_apply(st, a, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset asserted from time zero with every strobe high: outputs must read zero with no clock edge.
    reset = 1'b0;
    drive(9'h1FF, 'hA, 'h3);
    model_reset();
    #2;
    check_all("por_async");
    @(posedge clk);
    #1;
    check_all("por_held");
    @(negedge clk);
    reset = 1'b1;
    drive(S_NONE, 0, 0);

    step("add", S_ADD, 7, 5);
    check("add_lit", 32'(out), 32'd12);
    step("sub", S_SUB, 7, 5);
    check("sub_lit", 32'(out), 32'd2);
    step("lsr", S_LSR, 7, 0);
    check("lsr_lit", 32'(sr_q), 32'd7);
    step("lsh_c1", S_LSH, 7, 0);
    step("lsh_c2", S_LSH, 7, 0);
    check("lsh_lit", 32'(out), 32'd14);
    step("rsh", S_RSH, 7, 0);
    check("rsh_ov_lit", 32'(overflow), 32'd1);
    step("and", S_AND, 7, 5);
    step("or",  S_OR,  7, 5);
    step("xor", S_XOR, 7, 5);
    step("inv", S_INV, 7, 5);
    check("inv_lit", 32'(out), 32'd8);

    step("add_wrap", S_ADD, 15, 1);
    check("add_wrap_ov_lit", 32'(overflow), 32'd1);
    step("sub_wrap", S_SUB, 3, 5);
    check("sub_wrap_lit", 32'(out), 32'd14);
    step("lsh_msb", S_LSH, 8, 0);
    step("prio_add_xor", S_ADD | S_XOR, 7, 5);
    check("prio_lit", 32'(out), 32'd12);
    step("prio_all", 9'h1FE, 9, 3);  // SUB wins over everything below it

    for (int i = 0; i < 3; i++)
      step("hold", S_NONE, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));

    // Reset dropped mid-cycle while an ADD is being presented.
    step("pre_rst", S_ADD, 9, 9);
    @(negedge clk);
    drive(S_ADD, 6, 6);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst_async");
    @(posedge clk);
    #1;
    check_all("mid_rst_edge");
    @(negedge clk);
    reset = 1'b1;
    drive(S_NONE, 0, 0);
    step("post_rst", S_RSH, 5, 0);

    for (int i = 0; i < 300; i++) begin
      int r;
      logic [8:0] st;
      r = int'($urandom_range(0, 11));
      if (r < 9)       st = 9'(1 << r);
      else if (r == 9) st = S_NONE;
      else             st = 9'($urandom);
      step("rand", st, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arithmetic_logic_unit.md
Name: arithmetic_logic_unit

Overview:
- Small registered 4-bit ALU (width parameterised) for the microprocessor datapath.
- Executes one of nine operations, selected by one-hot operation strobes, on operands in1/in2.
- Result and overflow flag are registered on the rising clock edge.
- Contains an internal shift/data register (instance sr, register dataReg) that the LSR operation loads from in1.

Parameters:
- WIDTH, 4, operand/result/data-register width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ADD  input  1  op strobe: out = in1 + in2.
- SUB  input  1  op strobe: out = in1 - in2.
- LSR  input  1  op strobe: load the shift/data register with in1.
- LSH  input  1  op strobe: out = in1 shifted left by 1.
- RSH  input  1  op strobe: out = in1 shifted right by 1.
- AND  input  1  op strobe: bitwise in1 & in2.
- OR  input  1  op strobe: bitwise in1 | in2.
- XOR  input  1  op strobe: bitwise in1 ^ in2.
- INV  input  1  op strobe: bitwise ~in1.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out  output  WIDTH  registered result.
- overflow  output  1  registered carry/borrow/shift-out flag.
- sr_q  output  WIDTH  current value of sr.dataReg, for observability.

Behaviour:
- Reset: while reset = 0, asynchronously force out = 0, overflow = 0 and sr.dataReg = 0. Normal operation resumes on the first rising edge after reset returns high.
- Latency: one clock. The result of the operation sampled at rising edge N appears on out/overflow after edge N and holds until the next update.
- Strobe decode: strobes are nominally one-hot.
  - If several strobes are high, fixed priority applies: ADD > SUB > LSR > LSH > RSH > AND > OR > XOR > INV.
  - If no strobe is high, out, overflow and dataReg all hold.
- ADD: out = (in1 + in2) mod 2^WIDTH; overflow = carry out of the MSB.
- SUB: out = (in1 - in2) mod 2^WIDTH (two's complement); overflow = borrow, i.e. 1 when in1 < in2 unsigned.
- LSR: sr.dataReg <= in1. out and overflow hold their previous values.
- LSH: out = {in1[WIDTH-2:0], 0}; overflow = in1[WIDTH-1]. The result is computed from in1, not accumulated, so holding LSH over several cycles gives the same value every cycle.
- RSH: out = {0, in1[WIDTH-1:1]} (logical shift); overflow = in1[0]. Not accumulated.
- AND / OR / XOR: bitwise operation on in1 and in2; overflow = 0.
- INV: out = ~in1; overflow = 0.
- dataReg changes only on LSR or reset; sr_q always equals dataReg.
- All arithmetic is unsigned, WIDTH-bit, with wrap-around. No saturation.
- Reset asserted mid-operation: the in-flight result is discarded; outputs read 0 until the next active edge after release.

Test Plan:
- Reset low with arbitrary inputs -> out=0000, overflow=0, sr_q=0000 immediately, without waiting for a clock edge.
- in1=0111, in2=0101, ADD one cycle -> out=1100, ov=0. SUB -> out=0010, ov=0.
- in1=0111, LSR -> sr_q=0111, out unchanged. LSH held 2 cycles -> out=1110, ov=0 both cycles. RSH -> out=0011, ov=1.
- in1=0111, in2=0101: AND -> 0101; OR -> 0111; XOR -> 0010; INV -> 1000; ov=0 for each.
- Wrap: 1111+0001 -> out=0000, ov=1. 0011-0101 -> out=1110, ov=1. LSH of 1000 -> out=0000, ov=1.
- ADD and XOR both high, in1=0111, in2=0101 -> out=1100 (priority). All strobes low for 3 cycles -> out, overflow and sr_q hold.
